// File: rtl/ecg_axis_pkg.sv
// rtl/ecg_axis_pkg.sv - shared types, widths and helpers for the ECG AXIS sample source
package ecg_axis_pkg;

    localparam int ECG_SAMPLE_W = 16;
    localparam int DROP_CNT_W   = 16;

    typedef logic signed [ECG_SAMPLE_W-1:0] ecg_sample_t;

    // Counter that sticks at all-ones instead of wrapping back to zero.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (v == {DROP_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ecg_sync_fifo.sv
// rtl/ecg_sync_fifo.sv - register-array FIFO with fall-through read and push+pop on full
module ecg_sync_fifo
    import ecg_axis_pkg::*;
#(
    parameter int DATA_W = ECG_SAMPLE_W,
    parameter int DEPTH  = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic [LVL_W-1:0]  level_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              push_ok;
    logic              pop_ok;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign level_o = level_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A pop frees the slot being written, so a full FIFO may still accept a push.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            if (push_ok) mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/ecg_axis_sample_source.sv
// rtl/ecg_axis_sample_source.sv - strobed ADC samples to back-pressured AXIS, optional framing via ECG_AXIS_TLAST_EN
// Samples arriving while full with no pop are dropped and counted.
module ecg_axis_sample_source
    import ecg_axis_pkg::*;
#(
    parameter int DATA_W     = ECG_SAMPLE_W,
    parameter int FIFO_DEPTH = 4,
    parameter int FRAME_LEN  = 256,
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  adc_valid,
    input  logic [DATA_W-1:0]     adc_data,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tvalid,
    output logic [DATA_W-1:0]     m_axis_tdata,
`ifdef ECG_AXIS_TLAST_EN
    output logic                  m_axis_tlast,
`endif
    output logic [LVL_W-1:0]      fifo_level,
    output logic                  overflow,
    output logic [DROP_CNT_W-1:0] drop_count
);

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop;
    logic                  drop;
    logic                  overflow_q, overflow_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    // tvalid comes only from occupancy, never from tready.
    assign m_axis_tvalid = !fifo_empty;
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign drop          = adc_valid && fifo_full && !pop;

    ecg_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (adc_valid),
        .data_i  (adc_data),
        .pop_i   (pop),
        .data_o  (m_axis_tdata),
        .level_o (fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            overflow_d = 1'b1;
            drop_cnt_d = sat_inc(drop_cnt_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign overflow   = overflow_q;
    assign drop_count = drop_cnt_q;

`ifdef ECG_AXIS_TLAST_EN
    localparam int BEAT_W = $clog2(FRAME_LEN);

    logic [BEAT_W-1:0] beat_q, beat_d;

    // Advances only on handshakes, so tlast holds through stalls.
    always_comb begin
        beat_d = beat_q;
        if (pop) beat_d = (beat_q == BEAT_W'(FRAME_LEN - 1)) ? '0 : beat_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) beat_q <= '0;
        else     beat_q <= beat_d;
    end

    assign m_axis_tlast = (beat_q == BEAT_W'(FRAME_LEN - 1));
`else
    if (FRAME_LEN < 2) begin : g_frame_len_unused
    end
`endif

endmodule

// File: doc/ecg_axis_sample_source.md
# ecg_axis_sample_source

AXI4-Stream master that turns strobed ADC samples into a proper back-pressured stream for the ECG processing chain. It feeds the squaring stage and any other stage with a `s_axis_*` slave port. A small FIFO absorbs downstream stalls. Loss-of-data events are counted instead of silently corrupting the stream.

## Interface
- `DATA_W`, 16: sample width, signed two's complement.
- `FIFO_DEPTH`, 4: buffer entries; power of two, at least 2.
- `FRAME_LEN`, 256: beats per frame; used only when `ECG_AXIS_TLAST_EN` is defined; at least 2.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock, 50 MHz nominal.
- `rst`  in  1  async active-high reset.
- `adc_valid`  in  1  one-cycle strobe; `adc_data` is valid this cycle.
- `adc_data`  in  DATA_W  signed ADC sample.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_tvalid`  out  1  output beat valid.
- `m_axis_tdata`  out  DATA_W  output sample.
- `m_axis_tlast`  out  1  end of frame; present only with `ECG_AXIS_TLAST_EN`.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky; set on the first dropped sample.
- `drop_count`  out  16  number of dropped samples; saturates at 16'hFFFF.

## Operation
- Reset values: `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tlast`=0, `fifo_level`=0, `overflow`=0, `drop_count`=0. Pointers and frame counter are cleared.
- Push: `adc_valid`=1 and (level < FIFO_DEPTH, or a pop occurs in the same cycle). The sample is written at `wr_ptr`, which then increments mod FIFO_DEPTH.
- Drop: `adc_valid`=1, level==FIFO_DEPTH, and no pop this cycle. The sample is discarded, `drop_count` increments (saturating), and `overflow` sets. The FIFO is untouched.
- Pop: `m_axis_tvalid && m_axis_tready`. `rd_ptr` increments mod FIFO_DEPTH.
- Level update: +1 on push only, −1 on pop only, unchanged on push+pop.
- `m_axis_tvalid` = (level != 0). `m_axis_tdata` = mem[rd_ptr] (first-word fall-through).
- AXIS rules:
  - Once `m_axis_tvalid` is asserted, it is never deasserted before a handshake.
  - `tdata` and `tlast` are stable while `tvalid && !tready`.
  - `tvalid` never depends combinationally on `tready`.
- Data passes bit-exact with no arithmetic. Negative samples are unchanged.
- When empty, `tready` is ignored and no pop occurs.
- Reset mid-stream drops all buffered samples. `tvalid` is low while `rst` is high. `overflow` and `drop_count` clear.

## Timing
- Latency: a sample strobed at edge N appears with `tvalid`=1 after edge N, i.e. it is available for handshake at edge N+1.
- Throughput: one beat per clock when `tready` is held high and one sample arrives per clock.
- Full with simultaneous push and pop: both complete in one cycle, level stays FIFO_DEPTH, no drop.
- Empty with push: the beat cannot be popped in the same cycle. There is no bypass, so the earliest handshake is at the next edge.
- Pointer wrap: `FIFO_DEPTH-1` → 0 with no bubble.

## Configuration
- `ECG_AXIS_TLAST_EN` defined:
  - A beat counter of $clog2(FRAME_LEN) bits advances on each handshake.
  - `m_axis_tlast` = (count == FRAME_LEN-1).
  - The counter wraps to 0 after the last beat of a frame.
  - The counter is held on stalls, so `tlast` stays stable.
- `ECG_AXIS_TLAST_EN` undefined: the `m_axis_tlast` port and the beat counter do not exist. The stream is unframed.

## Structure
- Package `ecg_axis_pkg`:
  - `ECG_SAMPLE_W`=16 localparam.
  - `ecg_sample_t` (signed logic [15:0]).
  - `DROP_CNT_W`=16.
  - Saturating-increment function.
- Sub-module `ecg_sync_fifo`: register-array FIFO with push/pop/level, fall-through read, and simultaneous push/pop on full. The top level adds drop accounting, AXIS mapping and tlast generation.

## Test plan
- Reset and single beat: assert `rst`, then check all outputs are 0. Release, strobe 16'sh0005 with `tready`=1. Expect `tvalid`=1 with `tdata`=0005 after the strobe edge, one handshake, then `level` returns to 0.
- Back-pressure and overflow:
  - Hold `tready`=0 and strobe 1,2,3,4. Expect `level`=4 and `tdata`=1 held.
  - Strobe 5. Expect it dropped, `overflow`=1, `drop_count`=1.
  - Raise `tready`. Expect 1,2,3,4 out in order, then `tvalid`=0.
- Full with simultaneous push/pop: fill to 4, then `tready`=1 while strobing 9. Expect it accepted, `level` stays 4, `drop_count` unchanged, and 9 emitted fifth.
- Signed pass-through and wrap: strobe −1..−10 back-to-back with `tready`=1. Expect FFFF..FFF6 in order, with pointers wrapping twice without a bubble.
- tlast (`ECG_AXIS_TLAST_EN`, FRAME_LEN=4): stream 8 samples. Expect `tlast` on beats 4 and 8. Stalling on beat 4 for 3 cycles keeps `tlast`=1 and `tdata` stable.
- Reset mid-operation: with `level`=3 and `overflow`=1, pulse `rst` for one cycle. Expect `tvalid`=0, `level`=0, `overflow`=0, `drop_count`=0 immediately, and a fresh stream afterward starting from the next strobed sample.
